// File: rtl/oled_text_scheduler.sv
// 4x16 character shadow buffer that sequences showchar/clear commands into the OLED driver.
// Define OLED_TEXT_DIRTY_EN for dirty-cell tracking; otherwise every cell is refreshed in a loop.
module oled_text_scheduler #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic       busy,
  output logic       all_clean,
  input  logic       drv_ready,
  output logic       drv_showchar,
  output logic       drv_clear,
  output logic [7:0] drv_charval,
  output logic [1:0] drv_row,
  output logic [3:0] drv_col
);

  localparam int unsigned NumCells = 64;

  typedef enum logic [2:0] {
    StInit,
    StScan,
    StSend,
    StWaitAck,
    StClrSend,
    StClrWait
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic       clr_pend_q;
  logic [7:0] buffer_q [NumCells];
  logic [5:0] wr_idx;
  logic       cell_dirty;
  logic       show_d, clear_d;

  assign wr_idx = {wr_row, wr_col};

  // The host write is ordered after the blanking so it survives a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumCells; i++) buffer_q[i] <= BLANK_CHAR;
    end else begin
      if (state_q == StClrSend) begin
        for (int i = 0; i < NumCells; i++) buffer_q[i] <= BLANK_CHAR;
      end
      if (wr_en) buffer_q[wr_idx] <= wr_char;
    end
  end

`ifdef OLED_TEXT_DIRTY_EN
  logic [NumCells-1:0] dirty_q;

  // A write to the cell being sent keeps it dirty so the new value is reissued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= '0;
    end else begin
      if (state_q == StClrSend) dirty_q <= '0;
      if (state_q == StSend) dirty_q[ptr_q] <= 1'b0;
      if (wr_en) dirty_q[wr_idx] <= 1'b1;
    end
  end

  assign cell_dirty = dirty_q[ptr_q];
  assign all_clean  = !clr_pend_q && (dirty_q == '0);
`else
  assign cell_dirty = 1'b1;
  assign all_clean  = 1'b0;
`endif

  // A request arriving while the clear is being issued starts a fresh clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_q <= 1'b0;
    end else begin
      if (state_q == StClrSend) clr_pend_q <= 1'b0;
      if (clr_req) clr_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    show_d  = 1'b0;
    clear_d = 1'b0;
    unique case (state_q)
      StInit: begin
        if (drv_ready) state_d = StScan;
      end
      StScan: begin
        if (clr_pend_q && drv_ready) begin
          state_d = StClrSend;
          clear_d = 1'b1;
        end else if (cell_dirty && drv_ready) begin
          state_d = StSend;
          show_d  = 1'b1;
        end else if (!cell_dirty) begin
          ptr_d = ptr_q + 6'd1;
        end
      end
      StSend: begin
        ptr_d   = ptr_q + 6'd1;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (drv_ready) state_d = StScan;
      end
      StClrSend: begin
        state_d = StClrWait;
      end
      StClrWait: begin
        if (drv_ready) state_d = StScan;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      drv_showchar <= 1'b0;
      drv_clear    <= 1'b0;
      drv_charval  <= '0;
      drv_row      <= '0;
      drv_col      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      drv_showchar <= show_d;
      drv_clear    <= clear_d;
      // Cell data is captured on the issuing edge and held until the next send.
      if (show_d) begin
        drv_charval <= buffer_q[ptr_q];
        drv_row     <= ptr_q[5:4];
        drv_col     <= ptr_q[3:0];
      end
    end
  end

  assign busy = (state_q != StScan);

endmodule

// File: tb/tb_oled_text_scheduler.sv
// Directed self-checking bench for oled_text_scheduler with a behavioural driver-ready model.
// Expectations follow OLED_TEXT_DIRTY_EN when defined, full-refresh behaviour otherwise.
module tb_oled_text_scheduler;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       busy;
  logic       all_clean;
  logic       drv_ready;
  logic       drv_showchar;
  logic       drv_clear;
  logic [7:0] drv_charval;
  logic [1:0] drv_row;
  logic [3:0] drv_col;

  int n_cmp = 0;
  int n_err = 0;
  int n_show = 0;
  int n_clr = 0;
  bit acc = 1'b0;
  bit model_en = 1'b0;
  logic model_rdy;

`ifdef OLED_TEXT_DIRTY_EN
  localparam logic ExpClean = 1'b1;
`else
  localparam logic ExpClean = 1'b0;
`endif

  oled_text_scheduler #(.BLANK_CHAR(8'h20)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_char     (wr_char),
    .clr_req     (clr_req),
    .busy        (busy),
    .all_clean   (all_clean),
    .drv_ready   (drv_ready),
    .drv_showchar(drv_showchar),
    .drv_clear   (drv_clear),
    .drv_charval (drv_charval),
    .drv_row     (drv_row),
    .drv_col     (drv_col)
  );

  assign drv_ready = model_en & model_rdy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor, sampled away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      acc = drv_showchar | drv_clear;
      if (drv_showchar) n_show++;
      if (drv_clear) n_clr++;
    end
  end

  // Driver model: ready drops on the accept edge and returns 20 cycles later.
  initial begin
    int cnt;
    cnt = 0;
    model_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!model_en) begin
        cnt = 0;
        model_rdy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) model_rdy = 1'b1;
      end else if (acc) begin
        model_rdy = 1'b0;
        cnt = 20;
      end
    end
  end

  task automatic quiet();
    @(negedge clk);
    model_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic wr(input logic [1:0] row, input logic [3:0] col, input logic [7:0] ch,
                    input logic clr);
    wr_en = 1'b1;
    wr_row = row;
    wr_col = col;
    wr_char = ch;
    clr_req = clr;
    @(negedge clk);
    wr_en = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wait_issue(input bit any, input logic [5:0] idx, output bit found,
                            output logic [7:0] ch, output logic [5:0] got);
    found = 1'b0;
    ch = 8'h00;
    got = 6'h00;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (drv_showchar && (any || ({drv_row, drv_col} == idx))) begin
        found = 1'b1;
        ch = drv_charval;
        got = {drv_row, drv_col};
        break;
      end
    end
  endtask

  task automatic chk_found(input string name, input bit found);
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s: no showchar within budget, required one", name);
    end
  endtask

  task automatic test_reset();
    bit bad;
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    rst_n = 1'b1;
    wr_en = 1'b0;
    wr_row = '0;
    wr_col = '0;
    wr_char = '0;
    clr_req = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    n_cmp++;
    if ({drv_showchar, drv_clear, drv_charval, drv_row, drv_col} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {drv_showchar, drv_clear, drv_charval, drv_row, drv_col});
    end
    n_cmp++;
    if (busy !== 1'b1 || all_clean !== ExpClean) begin
      n_err++;
      $display("FAIL reset_status: busy=%b all_clean=%b required 1/%b", busy, all_clean, ExpClean);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL init_busy: busy dropped while not ready, required 1");
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (n_show + n_clr != 0) begin
      n_err++;
      $display("FAIL init_no_cmd: got %0d commands required 0", n_show + n_clr);
    end
    @(negedge clk);
    model_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL init_exit: busy=%b required 0", busy);
    end
`ifdef OLED_TEXT_DIRTY_EN
    repeat (100) @(posedge clk);
    #1;
    n_cmp++;
    if (n_show + n_clr != 0 || all_clean !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_init: cmds=%0d all_clean=%b required 0/1", n_show + n_clr, all_clean);
    end
`else
    wait_issue(1'b1, 6'd0, f, ch, got);
    chk_found("refresh_first", f);
    n_cmp++;
    if (got !== 6'd0 || ch !== 8'h20) begin
      n_err++;
      $display("FAIL refresh_first: cell %0d char %h required cell 0 char 20", got, ch);
    end
`endif
  endtask

  task automatic test_single_write();
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    int s0;
    quiet();
    s0 = n_show;
    wr(2'd1, 4'd5, 8'h41, 1'b0);
    model_en = 1'b1;
`ifdef OLED_TEXT_DIRTY_EN
    wait_issue(1'b1, 6'd21, f, ch, got);
`else
    wait_issue(1'b0, 6'd21, f, ch, got);
`endif
    chk_found("single_issue", f);
    n_cmp++;
    if (ch !== 8'h41 || drv_row !== 2'd1 || drv_col !== 4'd5) begin
      n_err++;
      $display("FAIL single_issue: char %h row %0d col %0d required 41 1 5", ch, drv_row, drv_col);
    end
    repeat (200) @(posedge clk);
    #1;
`ifdef OLED_TEXT_DIRTY_EN
    n_cmp++;
    if (n_show - s0 != 1 || all_clean !== 1'b1) begin
      n_err++;
      $display("FAIL single_once: issues %0d all_clean %b required 1/1", n_show - s0, all_clean);
    end
`else
    n_cmp++;
    if (all_clean !== 1'b0) begin
      n_err++;
      $display("FAIL refresh_all_clean: got %b required 0", all_clean);
    end
`endif
  endtask

  task automatic test_overwrite();
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    int s0;
    quiet();
    s0 = n_show;
    wr(2'd2, 4'd3, 8'h41, 1'b0);
    wr(2'd2, 4'd3, 8'h42, 1'b0);
    model_en = 1'b1;
    wait_issue(1'b0, 6'd35, f, ch, got);
    chk_found("overwrite_issue", f);
    n_cmp++;
    if (ch !== 8'h42) begin
      n_err++;
      $display("FAIL overwrite_issue: char %h required 42", ch);
    end
`ifdef OLED_TEXT_DIRTY_EN
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if (n_show - s0 != 1) begin
      n_err++;
      $display("FAIL overwrite_once: issues %0d required 1", n_show - s0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    int s0;
    quiet();
    s0 = n_show;
    wr(2'd0, 4'd0, 8'h55, 1'b0);
    model_en = 1'b1;
    wait_issue(1'b0, 6'd0, f, ch, got);
    chk_found("collide_first", f);
    // Write the same cell in its SEND cycle.
    wr(2'd0, 4'd0, 8'h43, 1'b0);
    n_cmp++;
    if (ch !== 8'h55) begin
      n_err++;
      $display("FAIL collide_first: char %h required 55", ch);
    end
    wait_issue(1'b0, 6'd0, f, ch, got);
    chk_found("collide_second", f);
    n_cmp++;
    if (ch !== 8'h43) begin
      n_err++;
      $display("FAIL collide_second: char %h required 43", ch);
    end
`ifdef OLED_TEXT_DIRTY_EN
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if (n_show - s0 != 2 || all_clean !== 1'b1) begin
      n_err++;
      $display("FAIL collide_count: issues %0d all_clean %b required 2/1", n_show - s0, all_clean);
    end
`endif
  endtask

  task automatic test_clear();
    bit clr_seen;
    bit show_first;
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    int s0;
    quiet();
    wr(2'd0, 4'd1, 8'h61, 1'b0);
    wr(2'd3, 4'd15, 8'h62, 1'b1);
    s0 = n_show;
    model_en = 1'b1;
    clr_seen = 1'b0;
    show_first = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (drv_clear) begin
        clr_seen = 1'b1;
        break;
      end
      if (drv_showchar) begin
        show_first = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!clr_seen || show_first) begin
      n_err++;
      $display("FAIL clear_first: clear %b showchar_first %b required 1/0", clr_seen, show_first);
    end
`ifdef OLED_TEXT_DIRTY_EN
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if (n_show != s0 || all_clean !== 1'b1) begin
      n_err++;
      $display("FAIL clear_wipe: issues %0d all_clean %b required 0/1", n_show - s0, all_clean);
    end
`else
    wait_issue(1'b0, 6'd1, f, ch, got);
    chk_found("clear_blank_a", f);
    n_cmp++;
    if (ch !== 8'h20) begin
      n_err++;
      $display("FAIL clear_blank_a: char %h required 20", ch);
    end
    wait_issue(1'b0, 6'd63, f, ch, got);
    chk_found("clear_blank_b", f);
    n_cmp++;
    if (ch !== 8'h20) begin
      n_err++;
      $display("FAIL clear_blank_b: char %h required 20", ch);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit f;
    logic [7:0] ch;
    logic [5:0] got;
    int s0;
    quiet();
    wr(2'd0, 4'd0, 8'h99, 1'b0);
    model_en = 1'b1;
    wait_issue(1'b0, 6'd0, f, ch, got);
    chk_found("mid_issue", f);
    @(negedge clk);
    rst_n = 1'b0;
    model_en = 1'b0;
    #1;
    n_cmp++;
    if ({drv_showchar, drv_clear, drv_charval, drv_row, drv_col} !== 16'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h required 0",
               {drv_showchar, drv_clear, drv_charval, drv_row, drv_col});
    end
    n_cmp++;
    if (busy !== 1'b1 || all_clean !== ExpClean) begin
      n_err++;
      $display("FAIL mid_reset_status: busy=%b all_clean=%b required 1/%b", busy, all_clean, ExpClean);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    s0 = n_show;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reinit: busy=%b required 1", busy);
    end
    model_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reinit_exit: busy=%b required 0", busy);
    end
`ifdef OLED_TEXT_DIRTY_EN
    repeat (100) @(posedge clk);
    #1;
    n_cmp++;
    if (n_show != s0 || all_clean !== 1'b1) begin
      n_err++;
      $display("FAIL mid_idle: issues %0d all_clean %b required 0/1", n_show - s0, all_clean);
    end
`else
    wait_issue(1'b1, 6'd0, f, ch, got);
    chk_found("mid_restart", f);
    n_cmp++;
    if (got !== 6'd0 || ch !== 8'h20) begin
      n_err++;
      $display("FAIL mid_restart: cell %0d char %h required cell 0 char 20", got, ch);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overwrite();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
